// File: rtl/neuron_input_sequencer_pkg.sv
// Shared definitions for the neuron input sequencer: FSM encodings, the Flopoco
// 1.0 constant used by the optional bias slot, and the stored word width.
package neuron_input_sequencer_pkg;

  localparam logic [1:0] ST_LOAD      = 2'd0;
  localparam logic [1:0] ST_FULL_WAIT = 2'd1;
  localparam logic [1:0] ST_STREAM    = 2'd2;

  // Flopoco 1.0: exception field 2'b01 marks a normal number.
  localparam logic [33:0] FP_ONE_X2 = {2'b01, 32'h3F80_0000};
  localparam logic [31:0] FP_ONE_X0 = 32'h3F80_0000;

  function automatic int word_width(input int bit_width, input int extra_bits);
    return bit_width + extra_bits;
  endfunction

endpackage

// File: rtl/neuron_input_sequencer_if.sv
// Load port, stream port and control signals of the neuron input sequencer.
interface neuron_input_sequencer_if #(
  parameter int W     = 34,
  parameter int DEPTH = 4
);
  localparam int IW = $clog2(DEPTH);

  // A load word transfers on a rising edge where IN_VALID and IN_READY are both 1;
  // DATA_OUT has no back-pressure and is valid exactly when DATA_VALID is 1.
  logic          IN_VALID;
  logic          IN_READY;
  logic [W-1:0]  IN_DATA;
  logic          START;
  logic          FLUSH;
  logic          FULL;
  logic [W-1:0]  DATA_OUT;
  logic          DATA_VALID;
  logic [IW-1:0] ELEM_IDX;
  logic          ACC_EN;
  logic          LAST;

  modport master (
    output IN_VALID, IN_DATA, START, FLUSH,
    input  IN_READY, FULL, DATA_OUT, DATA_VALID, ELEM_IDX, ACC_EN, LAST
  );

  modport slave (
    input  IN_VALID, IN_DATA, START, FLUSH,
    output IN_READY, FULL, DATA_OUT, DATA_VALID, ELEM_IDX, ACC_EN, LAST
  );

endinterface

// File: rtl/neuron_input_sequencer_seq_vector_buffer.sv
// DEPTH x word register file holding one input vector: synchronous write,
// combinational read. Contents are not reset.
module seq_vector_buffer
  import neuron_input_sequencer_pkg::*;
#(
  parameter  int BIT_WIDTH  = 32,
  parameter  int EXTRA_BITS = 2,
  parameter  int DEPTH      = 4,
  localparam int W          = word_width(BIT_WIDTH, EXTRA_BITS),
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/neuron_input_sequencer.sv
// Input-vector sequencer feeding one neuron MACC. Optional macro SEQ_BIAS_SLOT_EN
// makes element 0 a constant 1.0 and loads only DEPTH-1 words.
module neuron_input_sequencer
  import neuron_input_sequencer_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,
  parameter int EXTRA_BITS = 2,
  parameter int DEPTH      = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  neuron_input_sequencer_if.slave bus,
  output logic [1:0]              dbg_state
);

  localparam int W  = word_width(BIT_WIDTH, EXTRA_BITS);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
`ifdef SEQ_BIAS_SLOT_EN
  localparam int FIRST = 1;
  localparam logic [W-1:0] BIAS_ONE = (EXTRA_BITS == 2) ? W'(FP_ONE_X2) : W'(FP_ONE_X0);
`else
  localparam int FIRST = 0;
`endif
  localparam int N_LOAD = DEPTH - FIRST;

  logic [1:0]    state;
  logic [CW-1:0] wr_cnt;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_addr;
  logic [W-1:0]  rd_word;
  logic [W-1:0]  elem_word;
  logic          load_hs;

  logic [W-1:0]  data_out_q;
  logic          data_valid_q;
  logic [IW-1:0] elem_idx_q;
  logic          acc_en_q;
  logic          last_q;

  // FLUSH wins over a simultaneous load handshake, so the write is gated by it.
  assign load_hs = bus.IN_VALID & bus.IN_READY & ~bus.FLUSH;
  assign wr_addr = IW'(wr_cnt) + IW'(FIRST);

  seq_vector_buffer #(
    .BIT_WIDTH  (BIT_WIDTH),
    .EXTRA_BITS (EXTRA_BITS),
    .DEPTH      (DEPTH)
  ) u_buf (
    .clk   (CLK),
    .we    (load_hs),
    .waddr (wr_addr),
    .wdata (bus.IN_DATA),
    .raddr (rd_idx),
    .rdata (rd_word)
  );

`ifdef SEQ_BIAS_SLOT_EN
  assign elem_word = (rd_idx == '0) ? BIAS_ONE : rd_word;
`else
  assign elem_word = rd_word;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= ST_LOAD;
      wr_cnt       <= '0;
      rd_idx       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      elem_idx_q   <= '0;
      acc_en_q     <= 1'b1;
      last_q       <= 1'b0;
    end else if (bus.FLUSH) begin
      state        <= ST_LOAD;
      wr_cnt       <= '0;
      rd_idx       <= '0;
      data_valid_q <= 1'b0;
      elem_idx_q   <= '0;
      acc_en_q     <= 1'b1;
      last_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      elem_idx_q   <= '0;
      acc_en_q     <= 1'b1;
      last_q       <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (load_hs) begin
            wr_cnt <= wr_cnt + CW'(1);
            if (wr_cnt == CW'(N_LOAD - 1)) state <= ST_FULL_WAIT;
          end
        end
        ST_FULL_WAIT: begin
          if (bus.START) begin
            state  <= ST_STREAM;
            rd_idx <= '0;
          end
        end
        ST_STREAM: begin
          // Free-running: one element per cycle, START is not looked at here.
          data_out_q   <= elem_word;
          data_valid_q <= 1'b1;
          elem_idx_q   <= rd_idx;
          acc_en_q     <= (rd_idx != '0);
          last_q       <= (rd_idx == IW'(DEPTH - 1));
          if (rd_idx == IW'(DEPTH - 1)) begin
            state  <= ST_FULL_WAIT;
            rd_idx <= '0;
          end else begin
            rd_idx <= rd_idx + IW'(1);
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  assign bus.IN_READY   = (state == ST_LOAD);
  assign bus.FULL       = (state == ST_FULL_WAIT) || (state == ST_STREAM);
  assign bus.DATA_OUT   = data_out_q;
  assign bus.DATA_VALID = data_valid_q;
  assign bus.ELEM_IDX   = elem_idx_q;
  assign bus.ACC_EN     = acc_en_q;
  assign bus.LAST       = last_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_neuron_input_sequencer.sv
// Scoreboard bench for neuron_input_sequencer: directed loads, passes, FLUSH and
// asynchronous RESET; adapts to SEQ_BIAS_SLOT_EN when it is defined.
module tb_neuron_input_sequencer;
  import neuron_input_sequencer_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = 34;
  localparam int IW    = 2;
  localparam int EW    = IW + 2 + W;
`ifdef SEQ_BIAS_SLOT_EN
  localparam int N_LOAD = DEPTH - 1;
  localparam bit BIAS   = 1'b1;
`else
  localparam int N_LOAD = DEPTH;
  localparam bit BIAS   = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  neuron_input_sequencer_if #(.W(W), .DEPTH(DEPTH)) bus ();
  logic [1:0] dbg_state;

  neuron_input_sequencer #(
    .BIT_WIDTH  (32),
    .EXTRA_BITS (2),
    .DEPTH      (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;

  logic [DEPTH-1:0][W-1:0] vec_a = {34'h3_FFFF_FFFF, 34'h0_3F00_0000, 34'h2_C0A0_0000, 34'h1_4049_0FDB};
  logic [DEPTH-1:0][W-1:0] vec_b = {34'h3_0000_0000, 34'h2_7F7F_FFFF, 34'h1_8000_0000, 34'h0_0000_0001};
  logic [DEPTH-1:0][W-1:0] vec_c = {34'h1_1234_5678, 34'h2_9ABC_DEF0, 34'h1_0F0F_0F0F, 34'h2_F0F0_F0F0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] elem(input logic [DEPTH-1:0][W-1:0] v, input int i);
    if (BIAS) begin
      if (i == 0) return FP_ONE_X2;
      return v[i-1];
    end
    return v[i];
  endfunction

  function automatic logic [EW-1:0] pack_exp(input int i, input logic [W-1:0] d);
    logic acc;
    logic lst;
    acc = (i != 0);
    lst = (i == DEPTH - 1);
    return {IW'(i), acc, lst, d};
  endfunction

  task automatic push_elems(input logic [DEPTH-1:0][W-1:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(pack_exp(i, elem(v, i)));
  endtask

  // Monitor: every presented element must match the head of the queue.
  always @(negedge CLK) begin
    if (RESET !== 1'b1 && bus.DATA_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_unexpected: got idx=%0d data=%0h expected no element",
                 bus.ELEM_IDX, bus.DATA_OUT);
      end else begin
        mon_exp = exp_q.pop_front();
        check("stream_elem", {bus.ELEM_IDX, bus.ACC_EN, bus.LAST, bus.DATA_OUT}, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_vec(input logic [DEPTH-1:0][W-1:0] v);
    for (int k = 0; k < N_LOAD; k++) begin
      bus.IN_VALID = 1'b1;
      bus.IN_DATA  = v[k];
      tick();
    end
    bus.IN_VALID = 1'b0;
    bus.IN_DATA  = '0;
  endtask

  task automatic start_pulse();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
  endtask

  task automatic check_idle_after_pass(input string tag);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_valid_low"}, bus.DATA_VALID, 1'b0);
    check({tag, "_acc_en"}, bus.ACC_EN, 1'b1);
    check({tag, "_last_low"}, bus.LAST, 1'b0);
    check({tag, "_state"}, dbg_state, ST_FULL_WAIT);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [5:0] pat;
    int k;
    RESET        = 1'b1;
    bus.IN_VALID = 1'b0;
    bus.IN_DATA  = '0;
    bus.START    = 1'b0;
    bus.FLUSH    = 1'b0;
    #12;
    check("rst_in_ready", bus.IN_READY, 1'b1);
    check("rst_full", bus.FULL, 1'b0);
    check("rst_data_valid", bus.DATA_VALID, 1'b0);
    check("rst_data_out", bus.DATA_OUT, '0);
    check("rst_elem_idx", bus.ELEM_IDX, '0);
    check("rst_acc_en", bus.ACC_EN, 1'b1);
    check("rst_last", bus.LAST, 1'b0);
    check("rst_state", dbg_state, ST_LOAD);
    RESET = 1'b0;
    tick();

    // Back-to-back load, then two identical single passes.
    load_vec(vec_a);
    check("load_a_in_ready", bus.IN_READY, 1'b0);
    check("load_a_full", bus.FULL, 1'b1);
    check("load_a_no_output", bus.DATA_VALID, 1'b0);
    push_elems(vec_a, DEPTH);
    start_pulse();
    repeat (5) tick();
    check_idle_after_pass("pass_a1");
    push_elems(vec_a, DEPTH);
    start_pulse();
    repeat (5) tick();
    check_idle_after_pass("pass_a2");

    // START held for 10 edges: exactly two passes, STREAM ignores START.
    push_elems(vec_a, DEPTH);
    push_elems(vec_a, DEPTH);
    bus.START = 1'b1;
    repeat (10) tick();
    bus.START = 1'b0;
    repeat (6) tick();
    check_idle_after_pass("held_start");

    // New vector with a gappy IN_VALID pattern.
    bus.FLUSH = 1'b1;
    tick();
    bus.FLUSH = 1'b0;
    check("flush_fw_in_ready", bus.IN_READY, 1'b1);
    check("flush_fw_full", bus.FULL, 1'b0);
    pat = 6'b101101;
    k = 0;
    for (int p = 0; p < 6; p++) begin
      if (pat[5-p] && k < N_LOAD) begin
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = vec_b[k];
        k++;
      end else begin
        bus.IN_VALID = 1'b0;
        bus.IN_DATA  = 34'h2_DEAD_BEEF;
      end
      tick();
    end
    check("gap_load_full", bus.FULL, 1'b1);
    check("gap_load_in_ready", bus.IN_READY, 1'b0);
    bus.IN_VALID = 1'b1;
    bus.IN_DATA  = 34'h3_BAD0_BAD0;
    repeat (2) tick();
    bus.IN_VALID = 1'b0;
    push_elems(vec_b, DEPTH);
    start_pulse();
    repeat (5) tick();
    check_idle_after_pass("pass_b");

    // FLUSH while element 2 is on the outputs.
    push_elems(vec_b, 3);
    start_pulse();
    repeat (3) tick();
    check("flush_at_idx", bus.ELEM_IDX, 2);
    bus.FLUSH = 1'b1;
    tick();
    bus.FLUSH = 1'b0;
    check("flush_data_valid", bus.DATA_VALID, 1'b0);
    check("flush_in_ready", bus.IN_READY, 1'b1);
    check("flush_full", bus.FULL, 1'b0);
    check("flush_last", bus.LAST, 1'b0);
    check("flush_acc_en", bus.ACC_EN, 1'b1);
    check("flush_drained", exp_q.size(), 0);

    // Asynchronous RESET while element 1 is presented.
    load_vec(vec_c);
    push_elems(vec_c, 2);
    start_pulse();
    repeat (2) tick();
    #6;
    RESET = 1'b1;
    #1;
    check("arst_data_valid", bus.DATA_VALID, 1'b0);
    check("arst_data_out", bus.DATA_OUT, '0);
    check("arst_elem_idx", bus.ELEM_IDX, '0);
    check("arst_acc_en", bus.ACC_EN, 1'b1);
    check("arst_last", bus.LAST, 1'b0);
    check("arst_in_ready", bus.IN_READY, 1'b1);
    check("arst_full", bus.FULL, 1'b0);
    check("arst_drained", exp_q.size(), 0);
    tick();
    RESET = 1'b0;
    tick();

    // Normal operation resumes after reset.
    load_vec(vec_c);
    check("post_rst_full", bus.FULL, 1'b1);
    push_elems(vec_c, DEPTH);
    start_pulse();
    repeat (5) tick();
    check_idle_after_pass("pass_c");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
